// File: rtl/mem_pkg.sv
// mem_pkg
// Constants and types shared between the memory module and the RAM stream loader.
//   ADDR_W / DATA_W : RAM address and word widths
//   LEN_W           : width of a transfer word count (0 .. 2^ADDR_W)
//   MAX_LEN         : largest legal transfer length
//   loader_state_t  : loader FSM states
package mem_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 10;
    localparam int LEN_W  = ADDR_W + 1;

    // A full sweep of the address space is the longest legal transfer.
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } loader_state_t;

    function automatic logic length_too_big(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN);
    endfunction

endpackage

// File: rtl/ram_write_port_hold.sv
// ram_write_port_hold
// Owns the RAM write port registers. The address is loaded at the start of
// a transfer and advances by one (wrapping) on every accepted write. A data
// load raises ram_write; address, data and request then stay frozen until
// the RAM accepts.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   addr_load     : load addr_init into the address register
//   addr_init     : first address of a transfer
//   data_load     : capture data_in and raise the write request
//   data_in       : word to write
//   ram_inready   : RAM accepts the pending write this cycle
//   ram_write     : write request to the RAM
//   ram_addr      : write address to the RAM
//   ram_indata    : write data to the RAM
//   accept        : combinational, high in the cycle the RAM takes the write
module ram_write_port_hold #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_init,
    input  logic              data_load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ram_inready,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_indata,
    output logic              accept
);

    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    assign accept = write_q & ram_inready;

    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (addr_load) begin
            addr_d = addr_init;
        end
        if (data_load) begin
            data_d  = data_in;
            write_d = 1'b1;
        end
        // The owning FSM never loads data while a write is pending, so
        // accept and data_load cannot collide.
        if (accept) begin
            write_d = 1'b0;
            addr_d  = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign ram_write  = write_q;
    assign ram_addr   = addr_q;
    assign ram_indata = data_q;

endmodule

// File: rtl/ram_stream_loader.sv
// ram_stream_loader
// Fills the data RAM from a valid/ready word stream. A start in IDLE
// captures the base address and word count; each stream word is then
// written to the next RAM address, waiting for RAM acceptance on every
// word. The processor is stalled for the whole transfer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a load (only looked at in IDLE)
//   base_addr    : first RAM address
//   length       : number of words, 0 .. 2^ADDR_W
//   s_valid/s_data/s_ready : input word stream
//   ram_write/ram_addr/ram_indata/ram_inready : RAM write port
//   cpu_stall    : processor stall request
//   busy         : transfer in progress
//   done         : one-cycle pulse at the end of a transfer
//   err          : one-cycle pulse on a rejected start
//   checksum     : sum mod 2^DATA_W of words written in this/last transfer
//   words_left   : words still to be written
module ram_stream_loader #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_indata,
    input  logic              ram_inready,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W:0]   words_left
);

    import mem_pkg::*;

    loader_state_t     state_q,      state_d;
    logic              s_ready_q,    s_ready_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;
    logic [DATA_W-1:0] checksum_q,   checksum_d;
    logic [ADDR_W:0]   words_left_q, words_left_d;

    logic addr_load;
    logic data_load;
    logic accept;

    ram_write_port_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port (
        .clk         (clk),
        .rst         (rst),
        .addr_load   (addr_load),
        .addr_init   (base_addr),
        .data_load   (data_load),
        .data_in     (s_data),
        .ram_inready (ram_inready),
        .ram_write   (ram_write),
        .ram_addr    (ram_addr),
        .ram_indata  (ram_indata),
        .accept      (accept)
    );

    always_comb begin
        state_d      = state_q;
        s_ready_d    = s_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        checksum_d   = checksum_q;
        words_left_d = words_left_q;
        addr_load    = 1'b0;
        data_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length > (ADDR_W+1)'(1) << ADDR_W) begin
                        // Rejected: flag it and leave all transfer state alone.
                        err_d = 1'b1;
                    end else if (length == '0) begin
                        // Empty transfer still reports completion.
                        addr_load    = 1'b1;
                        words_left_d = '0;
                        checksum_d   = '0;
                        busy_d       = 1'b1;
                        done_d       = 1'b1;
                        state_d      = FINISH;
                    end else begin
                        addr_load    = 1'b1;
                        words_left_d = length;
                        checksum_d   = '0;
                        busy_d       = 1'b1;
                        s_ready_d    = 1'b1;
                        state_d      = RECV;
                    end
                end
            end

            RECV: begin
                if (s_valid) begin
                    data_load = 1'b1;
                    s_ready_d = 1'b0;
                    state_d   = WRITE;
                end
            end

            WRITE: begin
                if (accept) begin
                    checksum_d   = checksum_q + ram_indata;
                    words_left_d = words_left_q - (ADDR_W+1)'(1);
                    if (words_left_q == (ADDR_W+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        s_ready_d = 1'b1;
                        state_d   = RECV;
                    end
                end
            end

            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                s_ready_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            checksum_q   <= '0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            checksum_q   <= checksum_d;
            words_left_q <= words_left_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign cpu_stall  = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign checksum   = checksum_q;
    assign words_left = words_left_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
module tb_ram_stream_loader;

    localparam int AW = 14;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_indata;
    logic          ram_inready;
    logic          cpu_stall;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] checksum;
    logic [AW:0]   words_left;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int stall_low_cnt = 0;
    int log_addr[$];
    int log_data[$];

    always #5 clk = ~clk;

    ram_stream_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ram_write(ram_write), .ram_addr(ram_addr), .ram_indata(ram_indata),
        .ram_inready(ram_inready), .cpu_stall(cpu_stall), .busy(busy),
        .done(done), .err(err), .checksum(checksum), .words_left(words_left)
    );

    // RAM side model: log every accepted write.
    always @(posedge clk) begin
        if (!rst && ram_write && ram_inready) begin
            log_addr.push_back(int'(ram_addr));
            log_data.push_back(int'(ram_indata));
        end
        if (!rst && done) done_cnt++;
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1; base_addr = b; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int gap);
        bit acc = 0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1; s_data = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (!cpu_stall) stall_low_cnt++;
            if (s_ready) acc = 1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL send_word timeout: word %h not accepted", d);
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; base_addr = 0; length = 0; s_valid = 0; s_data = 0; ram_inready = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({s_ready, ram_write, cpu_stall, busy, done, err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {s_ready, ram_write, cpu_stall, busy, done, err});
        end
        n_checks++; if ({ram_addr, ram_indata, checksum, words_left} !== '0) begin
            n_fail++; $display("FAIL reset_values: addr %h data %h sum %h left %h expected all 0", ram_addr, ram_indata, checksum, words_left);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        int n0 = log_addr.size();
        int d0 = done_cnt;
        bit seen;
        logic [DW-1:0] w [4] = '{10'h001, 10'h002, 10'h3FF, 10'h100};
        stall_low_cnt = 0;
        do_start(14'h0010, 15'd4);
        n_checks++; if ({busy, cpu_stall, s_ready} !== 3'b111) begin
            n_fail++; $display("FAIL basic_start_flags: got %b expected 111", {busy, cpu_stall, s_ready});
        end
        for (int i = 0; i < 4; i++) send_word(w[i], 0);
        wait_done(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_done: done not seen"); end
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL basic_stall_finish: got %b expected 1", cpu_stall); end
        n_checks++; if (checksum !== 10'h102) begin n_fail++; $display("FAIL basic_checksum: got %h expected 102", checksum); end
        @(negedge clk);
        n_checks++; if ({done, cpu_stall, busy} !== 3'b000) begin
            n_fail++; $display("FAIL basic_after_done: got %b expected 000", {done, cpu_stall, busy});
        end
        n_checks++; if (stall_low_cnt != 0) begin n_fail++; $display("FAIL basic_stall_held: %0d low cycles expected 0", stall_low_cnt); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        n_checks++; if (log_addr.size() - n0 != 4) begin
            n_fail++; $display("FAIL basic_write_count: got %0d expected 4", log_addr.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (log_addr[n0+i] != 16 + i || log_data[n0+i] != int'(w[i])) begin
                    n_fail++; $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, log_addr[n0+i], log_data[n0+i], 16 + i, w[i]);
                end
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_wrap;
        int n0 = log_addr.size();
        bit seen;
        int exp_a [3] = '{32'h3FFE, 32'h3FFF, 32'h0000};
        do_start(14'h3FFE, 15'd3);
        send_word(10'h005, 0); send_word(10'h006, 1); send_word(10'h007, 0);
        wait_done(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL wrap_done: done not seen"); end
        n_checks++; if (words_left !== 15'd0) begin n_fail++; $display("FAIL wrap_words_left: got %0d expected 0", words_left); end
        n_checks++; if (checksum !== 10'h012) begin n_fail++; $display("FAIL wrap_checksum: got %h expected 012", checksum); end
        n_checks++; if (log_addr.size() - n0 != 3) begin
            n_fail++; $display("FAIL wrap_write_count: got %0d expected 3", log_addr.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (log_addr[n0+i] != exp_a[i] || log_data[n0+i] != 5 + i) begin
                    n_fail++; $display("FAIL wrap_write%0d: got %h/%h expected %h/%h", i, log_addr[n0+i], log_data[n0+i], exp_a[i], 5 + i);
                end
            end
        end
        @(negedge clk);
        $display("test_wrap done");
    endtask

    task automatic test_ram_stall;
        int n0 = log_addr.size();
        bit seen;
        do_start(14'h0100, 15'd3);
        send_word(10'h0AA, 0);
        @(negedge clk);
        ram_inready = 1'b0;
        send_word(10'h155, 0);
        for (int c = 0; c < 5; c++) begin
            n_checks++; if ({ram_write, s_ready} !== 2'b10 || ram_addr !== 14'h0101 || ram_indata !== 10'h155) begin
                n_fail++; $display("FAIL stall_hold c%0d: write/ready %b addr %h data %h expected 10 0101 155", c, {ram_write, s_ready}, ram_addr, ram_indata);
            end
            @(negedge clk);
        end
        n_checks++; if (log_addr.size() - n0 != 1) begin n_fail++; $display("FAIL stall_no_extra: got %0d writes expected 1", log_addr.size() - n0); end
        ram_inready = 1'b1;
        send_word(10'h2DE, 0);
        wait_done(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_done: done not seen"); end
        n_checks++; if (checksum !== 10'h0DD) begin n_fail++; $display("FAIL stall_checksum: got %h expected 0dd", checksum); end
        n_checks++; if (log_addr.size() - n0 != 3) begin
            n_fail++; $display("FAIL stall_write_count: got %0d expected 3", log_addr.size() - n0);
        end else begin
            n_checks++; if (log_addr[n0+1] != 32'h101 || log_data[n0+1] != 32'h155 || log_addr[n0+2] != 32'h102 || log_data[n0+2] != 32'h2DE) begin
                n_fail++; $display("FAIL stall_writes: got %h/%h %h/%h expected 101/155 102/2de", log_addr[n0+1], log_data[n0+1], log_addr[n0+2], log_data[n0+2]);
            end
        end
        @(negedge clk);
        $display("test_ram_stall done");
    endtask

    task automatic test_bad_length;
        do_start(14'h0000, 15'd16385);
        n_checks++; if ({err, busy, cpu_stall} !== 3'b100) begin
            n_fail++; $display("FAIL bad_len_flags: err/busy/stall %b expected 100", {err, busy, cpu_stall});
        end
        n_checks++; if (checksum !== 10'h0DD) begin n_fail++; $display("FAIL bad_len_checksum: got %h expected 0dd", checksum); end
        @(negedge clk);
        n_checks++; if ({err, s_ready, busy} !== 3'b000) begin
            n_fail++; $display("FAIL bad_len_after: err/ready/busy %b expected 000", {err, s_ready, busy});
        end
        $display("test_bad_length done");
    endtask

    task automatic test_zero_length;
        int n0 = log_addr.size();
        int d0 = done_cnt;
        do_start(14'h0040, 15'd0);
        n_checks++; if ({done, busy, ram_write} !== 3'b110 || checksum !== 10'h000) begin
            n_fail++; $display("FAIL zero_len_finish: done/busy/write %b sum %h expected 110 000", {done, busy, ram_write}, checksum);
        end
        @(negedge clk);
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_len_after: done/busy %b expected 00", {done, busy}); end
        @(negedge clk);
        n_checks++; if (log_addr.size() != n0 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL zero_len_counts: writes %0d dones %0d expected 0 1", log_addr.size() - n0, done_cnt - d0);
        end
        $display("test_zero_length done");
    endtask

    task automatic test_gaps_midstart;
        int n0 = log_addr.size();
        int d0 = done_cnt;
        bit seen;
        logic [DW-1:0] w [4] = '{10'h011, 10'h022, 10'h033, 10'h044};
        int gaps [4] = '{3, 0, 5, 1};
        do_start(14'h0200, 15'd4);
        for (int i = 0; i < 4; i++) begin
            send_word(w[i], gaps[i]);
            if (i == 1) do_start(14'h0000, 15'd2);
        end
        wait_done(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL gaps_done: done not seen"); end
        n_checks++; if (checksum !== 10'h0AA) begin n_fail++; $display("FAIL gaps_checksum: got %h expected 0aa", checksum); end
        repeat (3) @(negedge clk);
        n_checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL gaps_single_done: dones %0d busy %b expected 1 0", done_cnt - d0, busy);
        end
        n_checks++; if (log_addr.size() - n0 != 4) begin
            n_fail++; $display("FAIL gaps_write_count: got %0d expected 4", log_addr.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (log_addr[n0+i] != 32'h200 + i || log_data[n0+i] != int'(w[i])) begin
                    n_fail++; $display("FAIL gaps_write%0d: got %h/%h expected %h/%h", i, log_addr[n0+i], log_data[n0+i], 32'h200 + i, w[i]);
                end
            end
        end
        $display("test_gaps_midstart done");
    endtask

    task automatic test_reset_mid_write;
        int n0;
        bit seen;
        do_start(14'h0300, 15'd2);
        ram_inready = 1'b0;
        send_word(10'h3C3, 0);
        n_checks++; if (ram_write !== 1'b1) begin n_fail++; $display("FAIL rst_pre_write: got %b expected 1", ram_write); end
        n0 = log_addr.size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({s_ready, ram_write, cpu_stall, busy, done, err} !== 6'b0 ||
                        {ram_addr, ram_indata, checksum, words_left} !== '0) begin
            n_fail++; $display("FAIL rst_mid_values: flags %b addr %h data %h sum %h left %h expected all 0",
                               {s_ready, ram_write, cpu_stall, busy, done, err}, ram_addr, ram_indata, checksum, words_left);
        end
        ram_inready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (log_addr.size() != n0 || ram_write !== 1'b0) begin
            n_fail++; $display("FAIL rst_dropped_write: writes %0d ram_write %b expected 0 0", log_addr.size() - n0, ram_write);
        end
        do_start(14'h0123, 15'd1);
        send_word(10'h2A5, 0);
        wait_done(seen);
        n_checks++; if (!seen || checksum !== 10'h2A5) begin
            n_fail++; $display("FAIL rst_reload_done: seen %b sum %h expected 1 2a5", seen, checksum);
        end
        n_checks++; if (log_addr.size() - n0 != 1) begin
            n_fail++; $display("FAIL rst_reload_count: got %0d expected 1", log_addr.size() - n0);
        end else begin
            n_checks++; if (log_addr[n0] != 32'h123 || log_data[n0] != 32'h2A5) begin
                n_fail++; $display("FAIL rst_reload_write: got %h/%h expected 123/2a5", log_addr[n0], log_data[n0]);
            end
        end
        @(negedge clk);
        $display("test_reset_mid_write done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ram_stall();
        test_bad_length();
        test_zero_length();
        test_gaps_midstart();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
